output_lock_mux: RTL and testbench

Two-input packet output stage sitting directly downstream of `rr_arbiter` in each router output port. It drives the arbiter's request vector from pending head flits and latches the arbiter's one-hot grant as a packet lock. It then forwards that input's flits through a registered output until the tail flit, and pulses the arbiter's update input so the round-robin mask advances once per packet.

---
 rtl/output_lock_mux.sv | 115 +++++++++++
 tb/tb_output_lock_mux.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_lock_mux.sv
// output_lock_mux: two-input packet output stage behind an rr_arbiter.
// Ports: clk/arst (sync, active-high), per-input flit valid/data/head/tail
// with in_ready_o accept, arb_req_o/arb_grant_i/arb_update_o to the
// arbiter, and a registered out_valid_o/out_data_o/out_tail_o output
// with out_ready_i backpressure.
module output_lock_mux #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic [1:0]              in_valid_i,
  input  logic [2*DATA_WIDTH-1:0] in_data_i,
  input  logic [1:0]              in_head_i,
  input  logic [1:0]              in_tail_i,
  output logic [1:0]              in_ready_o,
  output logic [1:0]              arb_req_o,
  input  logic [1:0]              arb_grant_i,
  output logic                    arb_update_o,
  output logic                    out_valid_o,
  output logic [DATA_WIDTH-1:0]   out_data_o,
  output logic                    out_tail_o,
  input  logic                    out_ready_i
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   owner;
  logic   owner_nxt;

  logic                  grant_ok;
  logic                  slot_free;
  logic                  accept;
  logic                  sel_tail;
  logic [DATA_WIDTH-1:0] sel_data;

  // Only a clean one-hot grant to a requesting input may form a lock.
  assign grant_ok =
    (arb_grant_i == 2'b01 && arb_req_o[0]) ||
    (arb_grant_i == 2'b10 && arb_req_o[1]);

  assign slot_free = ~out_valid_o | out_ready_i;

  assign sel_data = owner ? in_data_i[DATA_WIDTH +: DATA_WIDTH]
                          : in_data_i[0 +: DATA_WIDTH];
  assign sel_tail = in_tail_i[owner];

  // Accepts are suppressed while reset is asserted, so a mid-packet
  // reset can neither consume a flit nor pulse the arbiter update.
  assign accept = (state == LOCKED) & ~arst &
                  in_valid_i[owner] & slot_free;

  always_ff @(posedge clk) begin
    if (arst) begin
      state <= IDLE;
      owner <= 1'b0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    unique case (state)
      IDLE: begin
        if (grant_ok) begin
          state_nxt = LOCKED;
          owner_nxt = arb_grant_i[1];
        end
      end
      LOCKED: begin
        if (accept && sel_tail) begin
          state_nxt = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    arb_req_o    = 2'b00;
    in_ready_o   = 2'b00;
    arb_update_o = 1'b0;
    unique case (state)
      IDLE: begin
        arb_req_o = in_valid_i & in_head_i;
      end
      LOCKED: begin
        in_ready_o[owner] = slot_free & ~arst;
        arb_update_o      = accept & sel_tail;
      end
    endcase
  end

  // Load wins over drain; data and tail hold when the slot empties.
  always_ff @(posedge clk) begin
    if (arst) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_tail_o  <= 1'b0;
    end else if (accept) begin
      out_valid_o <= 1'b1;
      out_data_o  <= sel_data;
      out_tail_o  <= sel_tail;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_output_lock_mux.sv
// Self-checking bench for output_lock_mux with a round-robin arbiter
// model and a packet-order reference model built from queued packets.
module tb_output_lock_mux;

  localparam int DW = 32;

  typedef logic [DW+1:0] flit_t;
  typedef logic [DW:0]   oflit_t;

  logic          clk;
  logic          arst;
  logic [1:0]    in_valid;
  logic [2*DW-1:0] in_data;
  logic [1:0]    in_head;
  logic [1:0]    in_tail;
  logic [1:0]    in_ready;
  logic [1:0]    arb_req;
  logic [1:0]    arb_grant;
  logic          arb_update;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_tail;
  logic          out_ready;

  output_lock_mux #(.DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .arst         (arst),
    .in_valid_i   (in_valid),
    .in_data_i    (in_data),
    .in_head_i    (in_head),
    .in_tail_i    (in_tail),
    .in_ready_o   (in_ready),
    .arb_req_o    (arb_req),
    .arb_grant_i  (arb_grant),
    .arb_update_o (arb_update),
    .out_valid_o  (out_valid),
    .out_data_o   (out_data),
    .out_tail_o   (out_tail),
    .out_ready_i  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Round-robin arbiter model: priority moves past the last winner
  // whenever the update input is seen.
  logic       prio;
  logic       last;
  logic [1:0] rr_grant;
  bit         force_en;
  logic [1:0] force_g;

  always_comb begin
    rr_grant = 2'b00;
    if (arb_req[prio]) rr_grant[prio] = 1'b1;
    else if (arb_req[~prio]) rr_grant[~prio] = 1'b1;
  end

  assign arb_grant = force_en ? force_g : rr_grant;

  always_ff @(posedge clk) begin
    if (arst) begin
      prio <= 1'b0;
      last <= 1'b0;
    end else begin
      if (|rr_grant) last <= rr_grant[1];
      if (arb_update) prio <= ~last;
    end
  end

  int tests = 0;
  int fails = 0;
  int upd_cnt = 0;
  bit ptr = 1'b0;

  flit_t  q0[$];
  flit_t  q1[$];
  flit_t  pend0[$];
  flit_t  pend1[$];
  oflit_t expq[$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic add_pkt(input int k, input int len,
                         input logic [DW-1:0] base, input bit rnd);
    flit_t f;
    for (int j = 0; j < len; j++) begin
      f[DW-1:0] = rnd ? DW'($urandom) : base + DW'(j);
      f[DW]     = (j == len - 1);
      f[DW+1]   = (j == 0);
      if (k == 0) begin
        q0.push_back(f);
        pend0.push_back(f);
      end else begin
        q1.push_back(f);
        pend1.push_back(f);
      end
    end
  endtask

  // Whole packets leave in round-robin order over inputs with work left.
  task automatic plan(output int np);
    int    i;
    flit_t f;
    np = 0;
    while (pend0.size() != 0 || pend1.size() != 0) begin
      if (ptr == 1'b0) i = (pend0.size() != 0) ? 0 : 1;
      else             i = (pend1.size() != 0) ? 1 : 0;
      do begin
        f = (i == 1) ? pend1.pop_front() : pend0.pop_front();
        expq.push_back({f[DW], f[DW-1:0]});
      end while (!f[DW]);
      ptr = (i == 0);
      np++;
    end
  endtask

  task automatic drive();
    in_valid = 2'b00;
    in_head  = 2'b00;
    in_tail  = 2'b00;
    in_data  = '0;
    if (q0.size() != 0) begin
      in_valid[0] = 1'b1;
      {in_head[0], in_tail[0], in_data[0 +: DW]} = q0[0];
    end
    if (q1.size() != 0) begin
      in_valid[1] = 1'b1;
      {in_head[1], in_tail[1], in_data[DW +: DW]} = q1[0];
    end
  endtask

  task automatic tick(input int mode);
    logic [1:0] acc;
    oflit_t     e;
    @(negedge clk);
    drive();
    case (mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
    #1;
    acc = in_valid & in_ready;
    chk("update_on_tail", 64'(arb_update), 64'(|(acc & in_tail)));
    if (arb_update) upd_cnt++;
    if (out_valid && out_ready) begin
      if (expq.size() == 0) begin
        chk("extra_flit", 64'({out_tail, out_data}), 64'hDEAD);
      end else begin
        e = expq.pop_front();
        chk("out_flit", 64'({out_tail, out_data}), 64'(e));
      end
    end
    if (acc[0]) void'(q0.pop_front());
    if (acc[1]) void'(q1.pop_front());
  endtask

  task automatic run_empty(input int mode, input int budget);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || expq.size() != 0) &&
           n < budget) begin
      tick(mode);
      n++;
    end
    chk("drain_timeout", 64'(n < budget), 64'd1);
  endtask

  initial begin
    int np;
    int u0;
    force_en  = 1'b0;
    force_g   = 2'b00;
    arst      = 1'b1;
    out_ready = 1'b1;
    in_valid  = 2'b11;
    in_head   = 2'b11;
    in_tail   = 2'b00;
    in_data   = {32'h1111_1111, 32'h0000_0000};

    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_update", 64'(arb_update), 64'd0);
    end
    chk("rst_out_data", 64'(out_data), 64'd0);
    arst = 1'b0;
    in_valid = 2'b00;
    in_head  = 2'b00;

    add_pkt(0, 3, 32'hA0, 1'b0);
    plan(np);
    tick(1);
    chk("sp_c0_ready", 64'(in_ready), 64'd0);
    tick(1);
    chk("sp_c1_ready", 64'(in_ready), 64'b01);
    chk("sp_c1_valid", 64'(out_valid), 64'd0);
    tick(1);
    chk("sp_c2_data", 64'(out_data), 64'hA0);
    chk("sp_c2_update", 64'(arb_update), 64'd0);
    tick(1);
    chk("sp_c3_update", 64'(arb_update), 64'd1);
    chk("sp_c3_data", 64'(out_data), 64'hA1);
    tick(1);
    chk("sp_c4_data", 64'({out_tail, out_data}), 64'h1_0000_00A2);
    chk("sp_c4_idle", 64'(in_ready), 64'd0);
    chk("sp_queue", 64'(expq.size()), 64'd0);

    add_pkt(1, 1, 32'h55, 1'b0);
    plan(np);
    tick(1);
    chk("sf_c0_ready", 64'(in_ready), 64'd0);
    tick(1);
    chk("sf_c1_ready", 64'(in_ready), 64'b10);
    chk("sf_c1_update", 64'(arb_update), 64'd1);
    tick(1);
    chk("sf_c2_out", 64'({out_valid, out_tail, out_data}),
        64'h3_0000_0055);
    chk("sf_c2_idle", 64'(in_ready), 64'd0);

    add_pkt(0, 1, 32'h77, 1'b0);
    plan(np);
    force_en = 1'b1;
    force_g  = 2'b11;
    tick(1);
    tick(1);
    chk("bad_grant_11", 64'(in_ready), 64'd0);
    force_g = 2'b10;
    tick(1);
    tick(1);
    chk("bad_grant_noreq", 64'(in_ready), 64'd0);
    force_g = 2'b00;
    tick(1);
    tick(1);
    chk("bad_grant_zero", 64'(in_ready), 64'd0);
    force_en = 1'b0;
    run_empty(1, 20);

    add_pkt(0, 4, 32'hB0, 1'b0);
    plan(np);
    tick(1);
    tick(1);
    tick(1);
    for (int c = 0; c < 3; c++) begin
      tick(0);
      chk("bp_data", 64'({out_valid, out_data}), 64'h1_0000_00B1);
      chk("bp_ready", 64'(in_ready), 64'd0);
    end
    run_empty(1, 20);

    add_pkt(0, 4, 32'hC0, 1'b0);
    plan(np);
    tick(1);
    tick(1);
    tick(1);
    @(negedge clk);
    arst = 1'b1;
    #1;
    chk("mr_rst_update", 64'(arb_update), 64'd0);
    chk("mr_rst_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    arst = 1'b0;
    q0.delete();
    expq.delete();
    ptr = 1'b0;
    drive();
    #1;
    chk("mr_valid", 64'(out_valid), 64'd0);
    chk("mr_update", 64'(arb_update), 64'd0);
    add_pkt(1, 2, 32'hD0, 1'b0);
    add_pkt(0, 1, 32'hE0, 1'b0);
    u0 = upd_cnt;
    plan(np);
    run_empty(1, 30);
    chk("mr_updates", 64'(upd_cnt - u0), 64'(np));

    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < 2; k++) begin
        int n = $urandom_range(0, 3);
        for (int p = 0; p < n; p++)
          add_pkt(k, $urandom_range(1, 4), '0, 1'b1);
      end
      u0 = upd_cnt;
      plan(np);
      run_empty(2, 600);
      chk("rand_updates", 64'(upd_cnt - u0), 64'(np));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
